calc_io_frontend: RTL and testbench

Board-level I/O front end of the FPGA calculator: derives slow scan strobes from the 50 MHz board clock, debounces and encodes the 16-button keypad into 5-bit key codes, and drives a 6-digit multiplexed 7-segment display from a signed 32-bit value or message code. The calculator core sits between the keypad outputs and the display input; this block contains no arithmetic beyond display conversion.

---
 rtl/calc_io_frontend.sv | 235 +++++++++++++++++++++++
 tb/tb_calc_io_frontend.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_io_frontend.sv
// Calculator board I/O: scan strobes, debounced keypad encoder and
// 6-digit multiplexed 7-segment display driver with binary-to-BCD conversion.
module calc_io_frontend #(
   parameter int SW_DIV  = 250000,
   parameter int FND_DIV = 25000
) (
   input  logic        clock_50m,
   input  logic        rst,
   input  logic [15:0] pb,
   input  logic [31:0] fnd_serial,
   output logic        sw_clk,
   output logic        fnd_clk,
   output logic [4:0]  eBCD,
   output logic        clr,
   output logic [5:0]  fnd_s,
   output logic [7:0]  fnd_d
);
   localparam int SW_W  = (SW_DIV  > 2) ? $clog2(SW_DIV)  : 1;
   localparam int FND_W = (FND_DIV > 2) ? $clog2(FND_DIV) : 1;

   localparam logic [5:0][6:0] G_BLANK = '0;
   localparam logic [5:0][6:0] G_ERR   = {7'h00, 7'h79, 7'h50, 7'h50, 7'h5C, 7'h50};
   localparam logic [5:0][6:0] G_ADD   = {7'h00, 7'h00, 7'h00, 7'h77, 7'h5E, 7'h5E};
   localparam logic [5:0][6:0] G_SUB   = {7'h00, 7'h00, 7'h00, 7'h6D, 7'h1C, 7'h7C};
   localparam logic [5:0][6:0] G_MUL   = {7'h00, 7'h00, 7'h00, 7'h37, 7'h1C, 7'h38};
   localparam logic [5:0][6:0] G_DIV   = {7'h00, 7'h00, 7'h00, 7'h5E, 7'h10, 7'h1C};
   localparam logic [5:0][6:0] G_MOD   = {7'h00, 7'h00, 7'h00, 7'h37, 7'h5C, 7'h5E};
   localparam logic [5:0][6:0] G_HAPPY = {7'h00, 7'h76, 7'h77, 7'h73, 7'h73, 7'h6E};

   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0: seg = 7'h3F;
         4'd1: seg = 7'h06;
         4'd2: seg = 7'h5B;
         4'd3: seg = 7'h4F;
         4'd4: seg = 7'h66;
         4'd5: seg = 7'h6D;
         4'd6: seg = 7'h7D;
         4'd7: seg = 7'h07;
         4'd8: seg = 7'h7F;
         4'd9: seg = 7'h6F;
         default: seg = 7'h00;
      endcase
   endfunction

   // Reset asserts asynchronously, releases two clocks after rst drops.
   logic [1:0] rst_ff;
   logic       rst_i;
   always_ff @(posedge clock_50m or posedge rst) begin
      if (rst) rst_ff <= 2'b11;
      else     rst_ff <= {rst_ff[0], 1'b0};
   end
   assign rst_i = rst_ff[1];

   logic [SW_W-1:0]  sw_cnt;
   logic [FND_W-1:0] fnd_cnt;
   logic             sw_tick, fnd_tick;

   always_ff @(posedge clock_50m or posedge rst_i) begin
      if (rst_i) begin
         sw_cnt  <= '0;
         sw_clk  <= 1'b0;
         sw_tick <= 1'b0;
      end else begin
         sw_cnt  <= (sw_cnt == SW_W'(SW_DIV - 1)) ? '0 : sw_cnt + 1'b1;
         sw_tick <= (sw_cnt == '0);
         if (sw_cnt == '0 || sw_cnt == SW_W'(SW_DIV / 2)) sw_clk <= ~sw_clk;
      end
   end

   always_ff @(posedge clock_50m or posedge rst_i) begin
      if (rst_i) begin
         fnd_cnt  <= '0;
         fnd_clk  <= 1'b0;
         fnd_tick <= 1'b0;
      end else begin
         fnd_cnt  <= (fnd_cnt == FND_W'(FND_DIV - 1)) ? '0 : fnd_cnt + 1'b1;
         fnd_tick <= (fnd_cnt == '0);
         if (fnd_cnt == '0 || fnd_cnt == FND_W'(FND_DIV / 2)) fnd_clk <= ~fnd_clk;
      end
   end

   // Keypad: synchronise the raw buttons, then compare successive strobe samples.
   logic [15:0] pb_s0, pb_s1, key_last, key_now;
   logic        released, one_hot;
   logic [3:0]  key_idx;

   assign key_now = ~pb_s1;
   assign one_hot = (key_now != 16'h0) && ((key_now & (key_now - 16'h1)) == 16'h0);

   always_comb begin
      key_idx = 4'd0;
      for (int i = 0; i < 16; i++)
         if (key_now[i]) key_idx = 4'(i);
   end

   always_ff @(posedge clock_50m or posedge rst_i) begin
      if (rst_i) begin
         pb_s0    <= '1;
         pb_s1    <= '1;
         key_last <= '0;
         released <= 1'b1;
         eBCD     <= '0;
         clr      <= 1'b0;
      end else begin
         pb_s0 <= pb;
         pb_s1 <= pb_s0;
         eBCD  <= '0;
         clr   <= 1'b0;
         if (sw_tick) begin
            key_last <= key_now;
            if (key_now == key_last) begin
               if (released && one_hot) begin
                  eBCD     <= {1'b1, key_idx};
                  clr      <= (key_idx == 4'd15);
                  released <= 1'b0;
               end else if (key_now == 16'h0) begin
                  released <= 1'b1;
               end
            end
         end
      end
   end

   // Display conversion
   typedef enum logic [1:0] {IDLE, CONV, DONE} conv_t;
   conv_t           st;
   logic [31:0]     val_q, cur_val;
   logic            loaded, neg;
   logic [19:0]     bin, mag;
   logic [23:0]     bcd, bcd_adj;
   logic [4:0]      step;
   logic [5:0][6:0] glyph, num_glyph, msg_glyph;
   logic            is_msg, out_rng;

   assign mag     = val_q[31] ? 20'(~val_q + 32'd1) : val_q[19:0];
   assign out_rng = ($signed(val_q) > 32'sd999999) || ($signed(val_q) < -32'sd99999);

   always_comb begin
      is_msg    = 1'b1;
      msg_glyph = G_BLANK;
      case (val_q)
         32'h00CC_0000: msg_glyph = G_BLANK;
         32'h00EE_0000: msg_glyph = G_ERR;
         32'h0010_0000: msg_glyph = G_ADD;
         32'h0020_0000: msg_glyph = G_SUB;
         32'h0030_0000: msg_glyph = G_MUL;
         32'h0040_0000: msg_glyph = G_DIV;
         32'h0050_0000: msg_glyph = G_MOD;
         32'h00A0_0000: msg_glyph = G_HAPPY;
         default:       is_msg    = 1'b0;
      endcase
   end

   always_comb begin
      bcd_adj = bcd;
      for (int d = 0; d < 6; d++)
         if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
   end

   // Leading zeros blank; the sign sits just left of the top nonzero digit.
   always_comb begin
      int msd;
      msd       = 0;
      num_glyph = G_BLANK;
      for (int i = 0; i < 6; i++)
         if (bcd[4*i +: 4] != 4'd0) msd = i;
      for (int i = 0; i < 6; i++) begin
         if (i <= msd)                 num_glyph[i] = seg(bcd[4*i +: 4]);
         else if (neg && i == msd + 1) num_glyph[i] = 7'h40;
      end
   end

   always_ff @(posedge clock_50m or posedge rst_i) begin
      if (rst_i) begin
         val_q   <= '0;
         cur_val <= '0;
         loaded  <= 1'b0;
         neg     <= 1'b0;
         bin     <= '0;
         bcd     <= '0;
         step    <= '0;
         glyph   <= G_BLANK;
         st      <= IDLE;
      end else begin
         val_q <= fnd_serial;
         if (!loaded || val_q != cur_val) begin
            loaded  <= 1'b1;
            cur_val <= val_q;
            neg     <= val_q[31];
            bin     <= mag;
            bcd     <= '0;
            step    <= '0;
            st      <= IDLE;
            if (is_msg)       glyph <= msg_glyph;
            else if (out_rng) glyph <= G_ERR;
            else              st    <= CONV;
         end else begin
            case (st)
               CONV: begin
                  bcd  <= {bcd_adj[22:0], bin[19]};
                  bin  <= {bin[18:0], 1'b0};
                  step <= step + 5'd1;
                  if (step == 5'd19) st <= DONE;
               end
               DONE: begin
                  glyph <= num_glyph;
                  st    <= IDLE;
               end
               default: st <= IDLE;
            endcase
         end
      end
   end

   // Scan: the first tick after reset lands on digit 0.
   logic [2:0] scan_idx, scan_nxt;
   logic       scan_on;

   assign scan_nxt = (!scan_on || scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;

   always_ff @(posedge clock_50m or posedge rst_i) begin
      if (rst_i) begin
         scan_idx <= '0;
         scan_on  <= 1'b0;
         fnd_s    <= 6'b111111;
         fnd_d    <= '0;
      end else if (fnd_tick) begin
         scan_idx <= scan_nxt;
         scan_on  <= 1'b1;
         fnd_s    <= ~(6'b000001 << scan_nxt);
         fnd_d    <= {1'b0, glyph[scan_nxt]};
      end
   end
endmodule

// File: tb/tb_calc_io_frontend.sv
// Scoreboard bench for calc_io_frontend: key events and display scans
// are checked against expectations queued when the stimulus is applied.
module tb_calc_io_frontend;
   logic        clk = 1'b0, rst = 1'b1;
   logic [15:0] pb = '1;
   logic [31:0] fnd_serial = '0;
   logic        sw_clk, fnd_clk, clr;
   logic [4:0]  eBCD;
   logic [5:0]  fnd_s;
   logic [7:0]  fnd_d;

   int n_cmp = 0, n_bad = 0;
   logic [4:0]  key_q[$];
   logic [47:0] disp_q[$];

   calc_io_frontend #(.SW_DIV(4), .FND_DIV(2)) dut (
      .clock_50m(clk), .rst(rst), .pb(pb), .fnd_serial(fnd_serial),
      .sw_clk(sw_clk), .fnd_clk(fnd_clk), .eBCD(eBCD), .clr(clr),
      .fnd_s(fnd_s), .fnd_d(fnd_d));

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [6:0] segc(input byte c);
      case (c)
         "0": segc = 7'h3F; "1": segc = 7'h06; "2": segc = 7'h5B; "3": segc = 7'h4F;
         "4": segc = 7'h66; "5": segc = 7'h6D; "6": segc = 7'h7D; "7": segc = 7'h07;
         "8": segc = 7'h7F; "9": segc = 7'h6F; "-": segc = 7'h40; "A": segc = 7'h77;
         "d": segc = 7'h5E; "S": segc = 7'h6D; "u": segc = 7'h1C; "b": segc = 7'h7C;
         "M": segc = 7'h37; "L": segc = 7'h38; "i": segc = 7'h10; "v": segc = 7'h1C;
         "o": segc = 7'h5C; "r": segc = 7'h50; "E": segc = 7'h79; "H": segc = 7'h76;
         "P": segc = 7'h73; "Y": segc = 7'h6E;
         default: segc = 7'h00;
      endcase
   endfunction

   function automatic logic [47:0] exp_disp(input logic [31:0] v);
      string s;
      int    sv;
      logic [47:0] r;
      sv = $signed(v);
      case (v)
         32'h00CC_0000: s = "      ";
         32'h00EE_0000: s = " Error";
         32'h0010_0000: s = "   Add";
         32'h0020_0000: s = "   Sub";
         32'h0030_0000: s = "   MuL";
         32'h0040_0000: s = "   div";
         32'h0050_0000: s = "   Mod";
         32'h00A0_0000: s = " HAPPY";
         default: begin
            if (sv > 999999 || sv < -99999) s = " Error";
            else s = $sformatf("%6d", sv);
         end
      endcase
      for (int k = 0; k < 6; k++) r[8*k +: 8] = {1'b0, segc(s[5-k])};
      return r;
   endfunction

   // Key event monitor: every event must match the head of the queue.
   initial begin
      logic [4:0] e;
      forever begin
         @(negedge clk);
         if (eBCD != 5'h00 || clr) begin
            if (key_q.size() == 0) begin
               chk("ebcd_unexpected", {58'h0, clr, eBCD}, 64'h0);
            end else begin
               e = key_q.pop_front();
               chk($sformatf("ebcd_%02h", e), eBCD, e);
               chk($sformatf("clr_%02h", e), clr, e == 5'h1F);
            end
         end
      end
   end

   task automatic press(input int k);
      @(negedge clk);
      pb = ~(16'h1 << k);
      key_q.push_back({1'b1, 4'(k)});
      repeat (32) @(negedge clk);
      pb = '1;
      repeat (32) @(negedge clk);
   endtask

   task automatic show(input logic [31:0] v);
      logic [47:0] got, want;
      logic [5:0]  seen;
      @(negedge clk);
      fnd_serial = v;
      disp_q.push_back(exp_disp(v));
      repeat (25) @(posedge clk);
      got  = '0;
      seen = '0;
      for (int c = 0; c < 40 && seen != 6'h3F; c++) begin
         @(negedge clk);
         for (int j = 0; j < 6; j++)
            if (fnd_s == ~(6'b000001 << j)) begin
               got[8*j +: 8] = fnd_d;
               seen[j] = 1'b1;
            end
      end
      if (seen != 6'h3F) chk("scan_timeout", seen, 6'h3F);
      want = disp_q.pop_front();
      chk($sformatf("disp_%0h", v), got, want);
   endtask

   initial begin
      int rises[$];
      int hi, cyc;
      logic prev;

      repeat (5) @(negedge clk);
      chk("rst_sw_clk", sw_clk, 1'b0);
      chk("rst_fnd_clk", fnd_clk, 1'b0);
      chk("rst_ebcd", eBCD, 5'h00);
      chk("rst_clr", clr, 1'b0);
      chk("rst_fnd_s", fnd_s, 6'b111111);
      chk("rst_fnd_d", fnd_d, 8'h00);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_fnd_s", fnd_s, 6'b111111);
      chk("rel_sw_clk", sw_clk, 1'b0);

      // First scan select after release must be digit 0.
      cyc = 0;
      while (fnd_s == 6'b111111 && cyc < 20) begin @(negedge clk); cyc++; end
      chk("first_digit", fnd_s, 6'b111110);

      // sw_clk period and duty
      prev = sw_clk; hi = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (sw_clk && !prev) rises.push_back(c);
         if (sw_clk && rises.size() == 1) hi++;
         prev = sw_clk;
      end
      if (rises.size() >= 2) chk("sw_period", rises[1] - rises[0], 4);
      else chk("sw_rises", rises.size(), 2);
      chk("sw_high", hi, 2);

      rises.delete(); prev = fnd_clk; hi = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (fnd_clk && !prev) rises.push_back(c);
         if (fnd_clk && rises.size() == 1) hi++;
         prev = fnd_clk;
      end
      if (rises.size() >= 2) chk("fnd_period", rises[1] - rises[0], 2);
      else chk("fnd_rises", rises.size(), 2);
      chk("fnd_high", hi, 1);

      for (int k = 0; k < 16; k++) press(k);

      // Bounce on key 3: alternate every sample, then hold steady.
      for (int t = 0; t < 6; t++) begin
         pb = (t % 2 == 0) ? ~16'h0008 : 16'hFFFF;
         repeat (4) @(negedge clk);
      end
      pb = ~16'h0008;
      key_q.push_back(5'h13);
      repeat (80) @(negedge clk);
      pb = '1;
      repeat (32) @(negedge clk);
      pb = ~16'h0003;
      repeat (32) @(negedge clk);
      pb = '1;
      repeat (32) @(negedge clk);
      chk("key_q_empty", key_q.size(), 0);

      show(32'd1); show(32'd12); show(32'd123); show(32'd1234);
      show(32'd12345); show(32'd123456); show(32'd100000); show(32'd999999);
      show(-32'sd1); show(-32'sd12345); show(-32'sd99999);
      show(-32'sd100000); show(32'd1000000); show(32'd0);
      show(32'h00EE_0000); show(32'h0010_0000); show(32'h0020_0000);
      show(32'h0030_0000); show(32'h0040_0000); show(32'h0050_0000);
      show(32'h00A0_0000); show(32'h00CC_0000);

      // Change mid-conversion restarts it.
      @(negedge clk);
      fnd_serial = 32'd987654;
      repeat (8) @(negedge clk);
      show(32'd4321);

      // Asynchronous reset in the middle of a scan.
      @(negedge clk);
      #3 rst = 1'b1;
      #1;
      chk("mid_rst_fnd_s", fnd_s, 6'b111111);
      chk("mid_rst_fnd_d", fnd_d, 8'h00);
      chk("mid_rst_ebcd", eBCD, 5'h00);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
